// File: rtl/ifu_pkg.sv
// Shared widths, queue entry type and run/halt state for the instruction fetch unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ifu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifu_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_t;

  // Instructions are 16-bit, so fetch addresses always have bit 0 clear.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of DEPTH instruction entries with flush and occupancy count.
// Latency: a push in cycle N is visible at the head in cycle N+1 (no bypass).
// Backpressure: head is held until pop_rdy; push and pop may coincide at any occupancy, including full.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_vld,
  input  ifu_entry_t               push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output ifu_entry_t               head_dat,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  ifu_entry_t       store [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNTW-1:0]  count;
  logic             do_pop;

  assign do_pop   = pop_rdy && (count != '0);
  assign head_vld = (count != '0);
  assign head_dat = store[rd_ptr];
  assign occ      = count;

  // Ring-buffer pointers and count; a flush empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        store[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_vld, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC-ordered memory reads under a DEPTH credit cap and queues returned words for the core.
// Latency: grant in N, response >= N+1, ir_valid the cycle after the response.
// Backpressure: ir_ready stalls the queue; requests stop when queue + outstanding + stale reach DEPTH. IFU_ALIGN_CHECK_EN enables the misaligned-redirect halt.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_err
);

  localparam int QW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH) + 2;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [CW-1:0]   live_cnt;
  logic [CW-1:0]   stale_cnt;
  logic [CW-1:0]   credit_used;
  logic [QW-1:0]   occ;
  ifu_state_t      state;
  ifu_entry_t      push_dat;
  ifu_entry_t      head;
  logic            grant;
  logic            resp_live;
  logic            resp_stale;
  logic            push_vld;
  logic            misaligned;
  logic            halted;

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned = redirect_pc[0];
`else
  assign misaligned = 1'b0;
`endif

  assign halted      = (state == ST_HALT);
  // Every slot is either queued, in flight for the current stream, or in flight but doomed.
  assign credit_used = CW'(occ) + live_cnt + stale_cnt;
  assign mem_req     = !reset && !halted && !redirect_valid && (credit_used < CW'(DEPTH));
  assign mem_addr    = fetch_pc;
  assign grant       = mem_req && mem_gnt;

  // Responses drain the stale backlog first; only then do they belong to the live stream.
  assign resp_stale  = mem_rvalid && (stale_cnt != '0);
  assign resp_live   = mem_rvalid && (stale_cnt == '0);
  assign push_vld    = resp_live && !redirect_valid;
  assign push_dat    = '{instr: mem_rdata, pc: resp_pc};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (ir_ready),
    .head_vld (ir_valid),
    .head_dat (head),
    .occ      (occ)
  );

  assign ir    = head.instr;
  assign ir_pc = head.pc;

  // Fetch/response PCs and the live/stale request counters; a redirect turns all live requests stale.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      live_cnt  <= '0;
      stale_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= align_pc(redirect_pc);
      resp_pc   <= align_pc(redirect_pc);
      live_cnt  <= '0;
      stale_cnt <= stale_cnt + live_cnt + CW'(grant) - CW'(mem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (resp_live) begin
        resp_pc <= resp_pc + PC_STEP;
      end
      live_cnt <= live_cnt + CW'(grant) - CW'(resp_live);
      if (resp_stale) begin
        stale_cnt <= stale_cnt - CW'(1);
      end
    end
  end

  // Run/halt control with the sticky misaligned-redirect flag; only an aligned redirect or reset resumes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      if (misaligned) begin
        state     <= ST_HALT;
        fetch_err <= 1'b1;
      end else begin
        state     <= ST_RUN;
        fetch_err <= 1'b0;
      end
    end
  end

  // A response must always belong to some outstanding request.
  a_resp_has_owner: assert property (@(posedge clock) disable iff (reset)
    mem_rvalid |-> ((stale_cnt != '0) || (live_cnt != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: variable-latency memory model plus PC-stream scoreboard.
// Latency: n/a.
// Backpressure: ir_ready driven randomly or per directed phase.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'hFFFC;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        fetch_err;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pc;
    int          due;
  } req_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } sb_t;

  sb_t  exp_q[$];
  req_t pend_q[$];
  req_t new_req;
  sb_t  mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  int mem_lat;
  int since_restart = 0;
  int first_vld;
  int run_cnt;
  int g0;
  int p0;
  int seen;
  int rsel;
  bit exp_halt = 1'b0;
  bit exp_err = 1'b0;
  logic [15:0] rpc;
  logic rv_s;
  logic iv_s;

  // Instruction memory contents: a fixed function of the byte address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h8100 + a * 16'h0082;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // The core should now see a contiguous stream starting at pc.
  task automatic restart(input logic [15:0] pc);
    logic [15:0] p;
    p = pc;
    exp_q.delete();
    for (int k = 0; k < 600; k++) begin
      exp_q.push_back('{instr: mem_word(p), pc: p});
      p = p + 16'd2;
    end
    exp_halt = 1'b0;
    exp_err = 1'b0;
    since_restart = 0;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Called at a negedge: pulse redirect for one cycle, then set up the new expectation.
  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    if (pc[0]) begin
      exp_q.delete();
      exp_halt = 1'b1;
      exp_err = 1'b1;
      since_restart = 0;
    end else begin
      restart(pc);
    end
`else
    restart(pc & 16'hFFFE);
`endif
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    restart(RST_PC);
  endtask

  // Memory: grants at gnt_pct, answers in order after lat_min..lat_max cycles, resets with the DUT.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        pend_q.delete();
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;
        mem_rdata = 16'h0000;
        last_due = 0;
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_word(pend_q[0].pc);
          void'(pend_q.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata = 16'hDEAD;
        end
        mem_gnt = ($urandom_range(99) < 32'(gnt_pct));
      end
      #1;
      if (!reset && mem_req && mem_gnt) begin
        grant_cnt++;
        mem_lat = int'($urandom_range(32'(lat_max), 32'(lat_min)));
        new_req.pc = mem_addr;
        new_req.due = cyc + mem_lat;
        if (new_req.due <= last_due) new_req.due = last_due + 1;
        last_due = new_req.due;
        pend_q.push_back(new_req);
      end
      cyc++;
    end
  end

  // Monitor: every consumed instruction must be the next one of the expected stream.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        check("fetch_err", 32'(fetch_err), 32'(exp_err));
        if (exp_halt) check("halt_no_req", 32'(mem_req), 32'(0));
        if (mem_req) check("addr_lsb", 32'(mem_addr[0]), 32'(0));
        if (ir_valid && ir_ready && !redirect_valid) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_instr: got pc %0h instr %0h, none expected", ir_pc, ir);
          end else begin
            mon_e = exp_q.pop_front();
            check("ir_pc", 32'(ir_pc), 32'(mon_e.pc));
            check("ir", 32'(ir), 32'(mon_e.instr));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    ir_ready = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 16'h0000;

    // Reset values
    step();
    step();
    #4;
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_ir_valid", 32'(ir_valid), 32'(0));
    check("rst_ir", 32'(ir), 32'(0));
    check("rst_ir_pc", 32'(ir_pc), 32'(0));
    check("rst_fetch_err", 32'(fetch_err), 32'(0));

    // Zero-wait fill latency and one-per-cycle throughput, wrapping FFFC -> 0002
    step();
    ir_ready = 1'b1;
    reset = 1'b0;
    restart(RST_PC);
    first_vld = -1;
    for (int k = 0; k < 20; k++) begin
      #4;
      if (ir_valid && first_vld < 0) first_vld = k;
      step();
    end
    check("first_valid_cycle", 32'(first_vld), 32'(2));
    run_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      #4;
      if (ir_valid) run_cnt++;
      step();
    end
    check("throughput", 32'(run_cnt), 32'(16));

    // Stall: exactly DEPTH grants, request drops, queue full; then drain in order
    ir_ready = 1'b0;
    do_reset(2);
    g0 = grant_cnt;
    repeat (10) step();
    check("stall_grants", 32'(grant_cnt - g0), 32'(DEPTH));
    #4;
    check("stall_req_low", 32'(mem_req), 32'(0));
    check("stall_full_valid", 32'(ir_valid), 32'(1));
    step();
    ir_ready = 1'b1;
    p0 = n_pop;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #4;
      if (mem_req) seen = 1;
      step();
    end
    check("req_reassert", 32'(seen), 32'(1));
    repeat (8) step();
    check("drain_progress", 32'(n_pop - p0 >= 8), 32'(1));

    // Latency 3: two requests in flight when redirected to 0010
    lat_min = 3;
    lat_max = 3;
    do_reset(2);
    g0 = grant_cnt;
    step();
    step();
    check("inflight_before_redirect", 32'(grant_cnt - g0), 32'(2));
    p0 = n_pop;
    do_redirect(16'h0010);
    repeat (20) step();
    check("late_redirect_progress", 32'(n_pop - p0 >= 5), 32'(1));

    // Redirect coinciding with a response and a consume
    lat_min = 1;
    lat_max = 1;
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    #4;
    rv_s = mem_rvalid;
    iv_s = ir_valid;
    check("same_cycle_setup", 32'({rv_s, iv_s}), 32'(2'b11));
    step();
    redirect_valid = 1'b0;
    restart(16'h0100);
    #4;
    check("empty_after_redirect", 32'(ir_valid), 32'(0));
    p0 = n_pop;
    repeat (12) step();
    check("post_redirect_progress", 32'(n_pop - p0 >= 5), 32'(1));

    // Misaligned redirect
    do_redirect(16'h0007);
    #4;
`ifdef IFU_ALIGN_CHECK_EN
    check("misalign_err_set", 32'(fetch_err), 32'(1));
    check("misalign_req_low", 32'(mem_req), 32'(0));
    repeat (5) step();
    do_redirect(16'h0008);
    #4;
    check("aligned_err_clear", 32'(fetch_err), 32'(0));
`else
    check("misalign_err_tied", 32'(fetch_err), 32'(0));
`endif
    p0 = n_pop;
    repeat (12) step();
    check("resume_progress", 32'(n_pop - p0 >= 5), 32'(1));

    // Random traffic: grant rate, latency, ready, redirects and resets all randomized
    p0 = n_pop;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) begin
        gnt_pct = int'($urandom_range(100, 30));
        lat_max = int'($urandom_range(4, 1));
        lat_min = 1;
      end
      rsel = int'($urandom_range(999));
      if (rsel < 4) begin
        do_reset(int'($urandom_range(2, 1)));
      end else if (rsel < 30 || since_restart > 300) begin
        rpc = 16'($urandom);
        if ($urandom_range(3) != 0) rpc[0] = 1'b0;
        do_redirect(rpc);
      end else begin
        step();
      end
      ir_ready = ($urandom_range(3) != 0);
      since_restart++;
    end
    check("random_progress", 32'(n_pop - p0 > 100), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
